// File: rtl/ram_slot_arbiter_pkg.sv
// Shared types and constants for the RAM slot arbiter.
package ram_arb_pkg;

  localparam int unsigned DATA_W = 16;

  localparam logic [1:0] VIDEO_SLOT_DEF = 2'd0;
  localparam logic [1:0] AUX_SLOT_DEF   = 2'd2;

  // Which requester owns the RAM during the current slot.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    VIDEO = 2'd1,
    CPU   = 2'd2,
    AUX   = 2'd3
  } owner_t;

endpackage

// File: rtl/ram_slot_arbiter_if.sv
// Requester and SRAM-pin bundle for the RAM slot arbiter.
// slave = arbiter side, master = requesters/SRAM side.
interface ram_slot_arbiter_if
  import ram_arb_pkg::*;
#(
  parameter int unsigned ADDR_W = 22
) ();

  logic              video_req;
  logic [ADDR_W-1:0] video_addr;
  logic [DATA_W-1:0] video_data;
  logic              video_valid;

  logic              cpu_req;
  logic              cpu_we;
  logic [1:0]        cpu_be;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic [DATA_W-1:0] cpu_rdata;
  logic              cpu_ack;

  logic              aux_req;
  logic [ADDR_W-1:0] aux_addr;
  logic [DATA_W-1:0] aux_rdata;
  logic              aux_ack;

  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_we_n;
  logic              mem_oe_n;
  logic [1:0]        mem_be_n;

  modport slave (
    input  video_req, video_addr,
    output video_data, video_valid,
    input  cpu_req, cpu_we, cpu_be, cpu_addr, cpu_wdata,
    output cpu_rdata, cpu_ack,
    input  aux_req, aux_addr,
    output aux_rdata, aux_ack,
    output mem_addr, mem_wdata, mem_we_n, mem_oe_n, mem_be_n,
    input  mem_rdata
  );

  modport master (
    output video_req, video_addr,
    input  video_data, video_valid,
    output cpu_req, cpu_we, cpu_be, cpu_addr, cpu_wdata,
    input  cpu_rdata, cpu_ack,
    output aux_req, aux_addr,
    input  aux_rdata, aux_ack,
    input  mem_addr, mem_wdata, mem_we_n, mem_oe_n, mem_be_n,
    output mem_rdata
  );

endinterface

// File: rtl/ram_slot_arbiter_perf.sv
// Saturating performance counters (CPU wait cycles, granted video slots).
// Only instantiated when RAM_ARB_PERF_EN is defined.
module ram_arb_perf (
  input  logic        clk8,
  input  logic        reset,
  input  logic        cpu_wait_inc,
  input  logic        video_grant,
  output logic [15:0] perf_cpu_wait,
  output logic [15:0] perf_video_slots
);

  logic [15:0] cpu_wait_q, cpu_wait_d;
  logic [15:0] video_slots_q, video_slots_d;

  // Next counter values, sticking at all-ones.
  always_comb begin
    cpu_wait_d    = cpu_wait_q;
    video_slots_d = video_slots_q;
    if (cpu_wait_inc && (cpu_wait_q != '1)) cpu_wait_d = cpu_wait_q + 16'd1;
    if (video_grant && (video_slots_q != '1)) video_slots_d = video_slots_q + 16'd1;
  end

  // Counter registers.
  always_ff @(posedge clk8 or posedge reset) begin
    if (reset) begin
      cpu_wait_q    <= '0;
      video_slots_q <= '0;
    end else begin
      cpu_wait_q    <= cpu_wait_d;
      video_slots_q <= video_slots_d;
    end
  end

  assign perf_cpu_wait    = cpu_wait_q;
  assign perf_video_slots = video_slots_q;

endmodule

// File: rtl/ram_slot_arbiter.sv
// Time-multiplexes one 16-bit SRAM between video, CPU and aux requesters,
// one slot per clk8 cycle, with a free-running 2-bit busCycle phase.
// Optional macro: RAM_ARB_PERF_EN enables the saturating perf counters.
module ram_slot_arbiter
  import ram_arb_pkg::*;
#(
  parameter int unsigned ADDR_W     = 22,
  parameter logic [1:0]  VIDEO_SLOT = VIDEO_SLOT_DEF,
  parameter logic [1:0]  AUX_SLOT   = AUX_SLOT_DEF
) (
  input  logic                clk8,
  input  logic                reset,
  output logic [1:0]          busCycle,
  ram_slot_arbiter_if.slave   bus,
  output logic [15:0]         perf_cpu_wait,
  output logic [15:0]         perf_video_slots
);

  logic [1:0]        bus_cycle_q, bus_cycle_d;
  logic [1:0]        nxt_slot;
  owner_t            owner_q, owner_d;
  logic              cpu_req_m, aux_req_m;

  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic              mem_we_n_q, mem_we_n_d;
  logic              mem_oe_n_q, mem_oe_n_d;
  logic [1:0]        mem_be_n_q, mem_be_n_d;

  logic [DATA_W-1:0] video_data_q, video_data_d;
  logic              video_valid_q, video_valid_d;
  logic [DATA_W-1:0] cpu_rdata_q, cpu_rdata_d;
  logic              cpu_ack_q, cpu_ack_d;
  logic [DATA_W-1:0] aux_rdata_q, aux_rdata_d;
  logic              aux_ack_q, aux_ack_d;

  // State register: slot phase and current owner.
  always_ff @(posedge clk8 or posedge reset) begin
    if (reset) begin
      bus_cycle_q <= '0;
      owner_q     <= IDLE;
    end else begin
      bus_cycle_q <= bus_cycle_d;
      owner_q     <= owner_d;
    end
  end

  // Next-state: pick the owner of the slot being entered.
  // A requester is masked while it is being served and during its ack cycle,
  // because its level request is still high until it sees the ack.
  always_comb begin
    bus_cycle_d = bus_cycle_q + 2'd1;
    nxt_slot    = bus_cycle_q + 2'd1;
    cpu_req_m   = bus.cpu_req && (owner_q != CPU) && !cpu_ack_q;
    aux_req_m   = bus.aux_req && (owner_q != AUX) && !aux_ack_q;
    owner_d     = IDLE;
    if (nxt_slot == VIDEO_SLOT) begin
      if (bus.video_req)  owner_d = VIDEO;
      else if (cpu_req_m) owner_d = CPU;
    end else if (nxt_slot == AUX_SLOT) begin
      if (aux_req_m)      owner_d = AUX;
      else if (cpu_req_m) owner_d = CPU;
    end else if (cpu_req_m) begin
      owner_d = CPU;
    end
  end

  // Outputs: SRAM controls for the new owner, completion for the old owner.
  always_comb begin
    mem_addr_d    = mem_addr_q;
    mem_wdata_d   = mem_wdata_q;
    mem_we_n_d    = 1'b1;
    mem_oe_n_d    = 1'b1;
    mem_be_n_d    = 2'b11;
    unique case (owner_d)
      VIDEO: begin
        mem_addr_d = bus.video_addr;
        mem_oe_n_d = 1'b0;
        mem_be_n_d = 2'b00;
      end
      AUX: begin
        mem_addr_d = bus.aux_addr;
        mem_oe_n_d = 1'b0;
        mem_be_n_d = 2'b00;
      end
      CPU: begin
        mem_addr_d = bus.cpu_addr;
        mem_be_n_d = ~bus.cpu_be;
        if (bus.cpu_we) begin
          mem_we_n_d  = 1'b0;
          mem_wdata_d = bus.cpu_wdata;
        end else begin
          mem_oe_n_d  = 1'b0;
        end
      end
      default: ;
    endcase

    video_data_d  = video_data_q;
    video_valid_d = 1'b0;
    cpu_rdata_d   = cpu_rdata_q;
    cpu_ack_d     = 1'b0;
    aux_rdata_d   = aux_rdata_q;
    aux_ack_d     = 1'b0;
    unique case (owner_q)
      VIDEO: begin
        video_data_d  = bus.mem_rdata;
        video_valid_d = 1'b1;
      end
      CPU: begin
        cpu_ack_d = 1'b1;
        // mem_we_n_q is low exactly when the finishing CPU slot was a write.
        if (mem_we_n_q) cpu_rdata_d = bus.mem_rdata;
      end
      AUX: begin
        aux_rdata_d = bus.mem_rdata;
        aux_ack_d   = 1'b1;
      end
      default: ;
    endcase
  end

  // Registered SRAM pins, data and strobes.
  always_ff @(posedge clk8 or posedge reset) begin
    if (reset) begin
      mem_addr_q    <= '0;
      mem_wdata_q   <= '0;
      mem_we_n_q    <= 1'b1;
      mem_oe_n_q    <= 1'b1;
      mem_be_n_q    <= 2'b11;
      video_data_q  <= '0;
      video_valid_q <= 1'b0;
      cpu_rdata_q   <= '0;
      cpu_ack_q     <= 1'b0;
      aux_rdata_q   <= '0;
      aux_ack_q     <= 1'b0;
    end else begin
      mem_addr_q    <= mem_addr_d;
      mem_wdata_q   <= mem_wdata_d;
      mem_we_n_q    <= mem_we_n_d;
      mem_oe_n_q    <= mem_oe_n_d;
      mem_be_n_q    <= mem_be_n_d;
      video_data_q  <= video_data_d;
      video_valid_q <= video_valid_d;
      cpu_rdata_q   <= cpu_rdata_d;
      cpu_ack_q     <= cpu_ack_d;
      aux_rdata_q   <= aux_rdata_d;
      aux_ack_q     <= aux_ack_d;
    end
  end

  assign busCycle        = bus_cycle_q;
  assign bus.mem_addr    = mem_addr_q;
  assign bus.mem_wdata   = mem_wdata_q;
  assign bus.mem_we_n    = mem_we_n_q;
  assign bus.mem_oe_n    = mem_oe_n_q;
  assign bus.mem_be_n    = mem_be_n_q;
  assign bus.video_data  = video_data_q;
  assign bus.video_valid = video_valid_q;
  assign bus.cpu_rdata   = cpu_rdata_q;
  assign bus.cpu_ack     = cpu_ack_q;
  assign bus.aux_rdata   = aux_rdata_q;
  assign bus.aux_ack     = aux_ack_q;

`ifdef RAM_ARB_PERF_EN
  ram_arb_perf u_perf (
    .clk8             (clk8),
    .reset            (reset),
    .cpu_wait_inc     (bus.cpu_req && !cpu_ack_q),
    .video_grant      (owner_d == VIDEO),
    .perf_cpu_wait    (perf_cpu_wait),
    .perf_video_slots (perf_video_slots)
  );
`else
  assign perf_cpu_wait    = '0;
  assign perf_video_slots = '0;
`endif

endmodule

// File: tb/tb_ram_slot_arbiter.sv
// Self-checking bench for ram_slot_arbiter: per-cycle vector table fed
// through a scoreboard queue, plus a hand-written async-reset sequence.
module tb_ram_slot_arbiter;

  logic        clk8 = 1'b0;
  logic        reset;
  logic [1:0]  busCycle;
  logic [15:0] perf_cpu_wait, perf_video_slots;

  ram_slot_arbiter_if #(.ADDR_W(22)) bus ();

  ram_slot_arbiter #(.ADDR_W(22), .VIDEO_SLOT(2'd0), .AUX_SLOT(2'd2)) dut (
    .clk8             (clk8),
    .reset            (reset),
    .busCycle         (busCycle),
    .bus              (bus),
    .perf_cpu_wait    (perf_cpu_wait),
    .perf_video_slots (perf_video_slots)
  );

  always #5 clk8 = ~clk8;

  typedef struct packed {
    logic [1:0]  bc;
    logic        we_n;
    logic        oe_n;
    logic [1:0]  be_n;
    logic [21:0] addr;
    logic [15:0] wdata;
    logic        vv;
    logic [15:0] vdata;
    logic        cack;
    logic [15:0] crd;
    logic        aack;
    logic [15:0] ard;
  } out_t;

  typedef struct packed {
    logic        vreq;
    logic        creq;
    logic        cwe;
    logic [1:0]  cbe;
    logic [21:0] caddr;
    logic [15:0] cwd;
    logic        areq;
    logic [15:0] rd;
    out_t        exp;
  } vec_t;

  localparam int unsigned NV = 23;
  vec_t  vecs [NV];
  out_t  sb [$];
  int    errors = 0;
  int    checks = 0;

  function automatic vec_t mk(
    input logic vreq, creq, cwe, input logic [1:0] cbe, input logic [21:0] caddr,
    input logic [15:0] cwd, input logic areq, input logic [15:0] rd,
    input logic [1:0] bc, input logic we_n, oe_n, input logic [1:0] be_n,
    input logic [21:0] addr, input logic [15:0] wdata, input logic vv,
    input logic [15:0] vdata, input logic cack, input logic [15:0] crd,
    input logic aack, input logic [15:0] ard);
    vec_t v;
    v.vreq = vreq; v.creq = creq; v.cwe = cwe; v.cbe = cbe; v.caddr = caddr;
    v.cwd = cwd; v.areq = areq; v.rd = rd;
    v.exp.bc = bc; v.exp.we_n = we_n; v.exp.oe_n = oe_n; v.exp.be_n = be_n;
    v.exp.addr = addr; v.exp.wdata = wdata; v.exp.vv = vv; v.exp.vdata = vdata;
    v.exp.cack = cack; v.exp.crd = crd; v.exp.aack = aack; v.exp.ard = ard;
    return v;
  endfunction

  function automatic out_t sample();
    out_t o;
    o.bc = busCycle; o.we_n = bus.mem_we_n; o.oe_n = bus.mem_oe_n;
    o.be_n = bus.mem_be_n; o.addr = bus.mem_addr; o.wdata = bus.mem_wdata;
    o.vv = bus.video_valid; o.vdata = bus.video_data; o.cack = bus.cpu_ack;
    o.crd = bus.cpu_rdata; o.aack = bus.aux_ack; o.ard = bus.aux_rdata;
    return o;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic chk_out(input string name, input out_t act, input out_t exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h (bc=%0d we_n=%b oe_n=%b be_n=%b addr=%h cack=%b aack=%b vv=%b)",
               name, act, exp, act.bc, act.we_n, act.oe_n, act.be_n, act.addr,
               act.cack, act.aack, act.vv);
    end
  endtask

  initial begin
    out_t rst_exp;
    out_t act;
    out_t exp;

    // in: vreq creq cwe cbe caddr cwd areq rd | out: bc we_n oe_n be_n addr wdata vv vdata cack crd aack ard
    vecs[0]  = mk(0,0,0,2'b00,22'h0,16'h0,0,16'h0,     2'd1,1,1,2'b11,22'h0,     16'h0,   0,16'h0,   0,16'h0,   0,16'h0);
    vecs[1]  = mk(0,0,0,2'b00,22'h0,16'h0,0,16'h0,     2'd2,1,1,2'b11,22'h0,     16'h0,   0,16'h0,   0,16'h0,   0,16'h0);
    vecs[2]  = mk(0,0,0,2'b00,22'h0,16'h0,0,16'h0,     2'd3,1,1,2'b11,22'h0,     16'h0,   0,16'h0,   0,16'h0,   0,16'h0);
    vecs[3]  = mk(0,0,0,2'b00,22'h0,16'h0,0,16'h0,     2'd0,1,1,2'b11,22'h0,     16'h0,   0,16'h0,   0,16'h0,   0,16'h0);
    vecs[4]  = mk(0,0,0,2'b00,22'h0,16'h0,0,16'h0,     2'd1,1,1,2'b11,22'h0,     16'h0,   0,16'h0,   0,16'h0,   0,16'h0);
    vecs[5]  = mk(0,0,0,2'b00,22'h0,16'h0,0,16'h0,     2'd2,1,1,2'b11,22'h0,     16'h0,   0,16'h0,   0,16'h0,   0,16'h0);
    // video_req outside the edge entering slot 0 is ignored
    vecs[6]  = mk(1,0,0,2'b00,22'h0,16'h0,0,16'h0,     2'd3,1,1,2'b11,22'h0,     16'h0,   0,16'h0,   0,16'h0,   0,16'h0);
    vecs[7]  = mk(1,0,0,2'b00,22'h0,16'h0,0,16'hA5A5,  2'd0,1,0,2'b00,22'h3FA700,16'h0,   0,16'h0,   0,16'h0,   0,16'h0);
    // CPU write raised during video slot -> slot 1
    vecs[8]  = mk(0,1,1,2'b01,22'h100,16'h1234,0,16'hA5A5, 2'd1,0,1,2'b10,22'h100,16'h1234,1,16'hA5A5,0,16'h0,0,16'h0);
    vecs[9]  = mk(0,1,1,2'b01,22'h100,16'h1234,0,16'h0,    2'd2,1,1,2'b11,22'h100,16'h1234,0,16'hA5A5,1,16'h0,0,16'h0);
    vecs[10] = mk(0,0,0,2'b00,22'h0,16'h0,0,16'h0,     2'd3,1,1,2'b11,22'h100,   16'h1234,0,16'hA5A5,0,16'h0,   0,16'h0);
    vecs[11] = mk(0,0,0,2'b00,22'h0,16'h0,0,16'h0,     2'd0,1,1,2'b11,22'h100,   16'h1234,0,16'hA5A5,0,16'h0,   0,16'h0);
    vecs[12] = mk(0,0,0,2'b00,22'h0,16'h0,0,16'h0,     2'd1,1,1,2'b11,22'h100,   16'h1234,0,16'hA5A5,0,16'h0,   0,16'h0);
    // cpu_req and aux_req both entering slot 2: aux first, CPU in slot 3
    vecs[13] = mk(0,1,0,2'b11,22'h222,16'h0,1,16'h0,   2'd2,1,0,2'b00,22'h0ABCDE,16'h1234,0,16'hA5A5,0,16'h0,   0,16'h0);
    vecs[14] = mk(0,1,0,2'b11,22'h222,16'h0,1,16'hBEEF,2'd3,1,0,2'b00,22'h222,   16'h1234,0,16'hA5A5,0,16'h0,   1,16'hBEEF);
    vecs[15] = mk(0,1,0,2'b11,22'h222,16'h0,0,16'hC0DE,2'd0,1,1,2'b11,22'h222,   16'h1234,0,16'hA5A5,1,16'hC0DE,0,16'hBEEF);
    vecs[16] = mk(0,0,0,2'b00,22'h0,16'h0,0,16'h0,     2'd1,1,1,2'b11,22'h222,   16'h1234,0,16'hA5A5,0,16'hC0DE,0,16'hBEEF);
    vecs[17] = mk(0,0,0,2'b00,22'h0,16'h0,0,16'h0,     2'd2,1,1,2'b11,22'h222,   16'h1234,0,16'hA5A5,0,16'hC0DE,0,16'hBEEF);
    vecs[18] = mk(0,0,0,2'b00,22'h0,16'h0,0,16'h0,     2'd3,1,1,2'b11,22'h222,   16'h1234,0,16'hA5A5,0,16'hC0DE,0,16'hBEEF);
    // no video entering slot 0: pending CPU read takes it
    vecs[19] = mk(0,1,0,2'b10,22'h1234,16'h0,0,16'h0,  2'd0,1,0,2'b01,22'h1234,  16'h1234,0,16'hA5A5,0,16'hC0DE,0,16'hBEEF);
    vecs[20] = mk(0,1,0,2'b10,22'h1234,16'h0,0,16'h5A5A,2'd1,1,1,2'b11,22'h1234, 16'h1234,0,16'hA5A5,1,16'h5A5A,0,16'hBEEF);
    vecs[21] = mk(0,0,0,2'b00,22'h0,16'h0,0,16'h0,     2'd2,1,1,2'b11,22'h1234,  16'h1234,0,16'hA5A5,0,16'h5A5A,0,16'hBEEF);
    // CPU write in flight when reset hits
    vecs[22] = mk(0,1,1,2'b11,22'h300,16'hFFFF,0,16'h0,2'd3,0,1,2'b00,22'h300,   16'hFFFF,0,16'hA5A5,0,16'h5A5A,0,16'hBEEF);

    rst_exp = '0;
    rst_exp.we_n = 1'b1;
    rst_exp.oe_n = 1'b1;
    rst_exp.be_n = 2'b11;

    reset          = 1'b1;
    bus.video_req  = 1'b0;
    bus.video_addr = 22'h3FA700;
    bus.cpu_req    = 1'b0;
    bus.cpu_we     = 1'b0;
    bus.cpu_be     = 2'b00;
    bus.cpu_addr   = '0;
    bus.cpu_wdata  = '0;
    bus.aux_req    = 1'b0;
    bus.aux_addr   = 22'h0ABCDE;
    bus.mem_rdata  = '0;

    #12;
    chk_out("reset_state", sample(), rst_exp);
    chk("reset_perf_wait", {16'h0, perf_cpu_wait}, 32'h0);
    chk("reset_perf_video", {16'h0, perf_video_slots}, 32'h0);
    reset = 1'b0;

    for (int unsigned i = 0; i < NV; i++) begin
      bus.video_req = vecs[i].vreq;
      bus.cpu_req   = vecs[i].creq;
      bus.cpu_we    = vecs[i].cwe;
      bus.cpu_be    = vecs[i].cbe;
      bus.cpu_addr  = vecs[i].caddr;
      bus.cpu_wdata = vecs[i].cwd;
      bus.aux_req   = vecs[i].areq;
      bus.mem_rdata = vecs[i].rd;
      sb.push_back(vecs[i].exp);
      @(posedge clk8);
      #1;
      if (sb.size() == 0) begin
        errors++;
        checks++;
        $display("FAIL scoreboard_empty at vec%0d", i);
      end else begin
        act = sample();
        exp = sb.pop_front();
        chk_out($sformatf("vec%0d", i), act, exp);
      end
    end

    // Async reset mid-slot while the CPU write is on the pins.
    #2;
    reset = 1'b1;
    #1;
    chk("async_we_n", {31'h0, bus.mem_we_n}, 32'h1);
    chk("async_busCycle", {30'h0, busCycle}, 32'h0);
    chk("async_cpu_ack", {31'h0, bus.cpu_ack}, 32'h0);
    chk("async_perf_wait", {16'h0, perf_cpu_wait}, 32'h0);
    chk("async_perf_video", {16'h0, perf_video_slots}, 32'h0);
    @(posedge clk8);
    #1;
    chk_out("held_reset_state", sample(), rst_exp);
    bus.cpu_req = 1'b0;
    reset = 1'b0;
    @(posedge clk8);
    #1;
    chk("post_reset_busCycle", {30'h0, busCycle}, 32'h1);
    chk("post_reset_cpu_ack", {31'h0, bus.cpu_ack}, 32'h0);
    chk("post_reset_we_n", {31'h0, bus.mem_we_n}, 32'h1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout");
    $fatal(1);
  end

endmodule
